// File: rtl/gpio_bus_master_if.sv
// Command/response handshake plus GPIO register bus, bundled for the bus master.
// master: the initiator side; slave: the CPU/sequencer and gpio_ip side.
interface gpio_bus_master_if #(
  parameter int DATA_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_offset;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              sel;
  logic              write_en;
  logic              read_en;
  logic [1:0]        offset;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_offset, cmd_wdata, rsp_ready, rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel, write_en, read_en, offset, wdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_offset, cmd_wdata, rsp_ready, rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel, write_en, read_en, offset, wdata
  );
endinterface

// File: rtl/gpio_bus_master.sv
// Single-outstanding GPIO bus initiator: turns one accepted command into a timed
// bus cycle and returns its result on a registered response port.
module gpio_bus_master #(
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  gpio_bus_master_if.master bus,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count
);

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RESP} state_e;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LATENCY - 1);

  state_e            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [1:0]        offset_q, offset_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  txn_q, txn_d;
  logic              cmd_ready;
  logic              illegal;

  // Offset 3 is unmapped and offset 2 (pin input) is read-only.
  assign illegal = (bus.cmd_offset == 2'd3) || (bus.cmd_write && bus.cmd_offset == 2'd2);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    sel_d       = 1'b0;
    we_d        = 1'b0;
    re_d        = 1'b0;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    txn_d       = txn_q;
    cmd_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !rst;
        if (bus.cmd_valid) begin
          if (illegal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (bus.cmd_write) begin
            state_d  = WR;
            sel_d    = 1'b1;
            we_d     = 1'b1;
            offset_d = bus.cmd_offset;
            wdata_d  = bus.cmd_wdata;
          end else begin
            state_d  = RD;
            sel_d    = 1'b1;
            re_d     = 1'b1;
            offset_d = bus.cmd_offset;
          end
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        txn_d       = txn_q + 1'b1;
      end
      RD: begin
        state_d = RWAIT;
        wait_d  = WAIT_INIT;
      end
      RWAIT: begin
        // rdata is sampled on the edge that closes the last wait cycle.
        if (wait_q == 3'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = bus.rdata;
          txn_d       = txn_q + 1'b1;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      offset_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      txn_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      re_q        <= re_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      txn_q       <= txn_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.sel       = sel_q;
  assign bus.write_en  = we_q;
  assign bus.read_en   = re_q;
  assign bus.offset    = offset_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != IDLE);
  assign txn_count     = txn_q;

endmodule
